alu_pipe: RTL and testbench

Parametrised, registered successor to the team's 8-bit combinational ALU. It keeps the same arithmetic/logic opcode map, but widens the datapath to WIDTH bits and adds several new features: a valid/ready handshake on input and output, a registered status-flag word, and stored-carry chaining for multi-word arithmetic. An optional iterative multiplier can also be compiled in. It sits between the datapath sequencer (operand issue) and the register-file writeback stage.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_pipe.sv | 170 +++++++++++++++++
 tb/tb_alu_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions and FSM state type for alu_pipe.
// The multiplier opcodes are only legal when ALU_PIPE_MUL_EN is defined.
package alu_pkg;

  // Logic group (ext=0, mode=0)
  localparam logic [4:0] AND   = 5'b0_0000;
  localparam logic [4:0] OR    = 5'b0_0001;
  localparam logic [4:0] XOR   = 5'b0_0010;
  localparam logic [4:0] NOR   = 5'b0_0011;
  localparam logic [4:0] SHLA  = 5'b0_0100;
  localparam logic [4:0] SHLB  = 5'b0_0101;
  localparam logic [4:0] SRLA  = 5'b0_0110;
  localparam logic [4:0] SRLB  = 5'b0_0111;

  // Arithmetic group (ext=0, mode=1)
  localparam logic [4:0] ADD   = 5'b0_1000;
  localparam logic [4:0] SUB   = 5'b0_1001;
  localparam logic [4:0] INCA  = 5'b0_1010;
  localparam logic [4:0] INCB  = 5'b0_1011;
  localparam logic [4:0] DECA  = 5'b0_1100;
  localparam logic [4:0] DECB  = 5'b0_1101;
  localparam logic [4:0] PASSA = 5'b0_1110;
  localparam logic [4:0] PASSB = 5'b0_1111;

  localparam logic [4:0] MUL   = 5'b1_0000;
  localparam logic [4:0] MFHI  = 5'b1_0001;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: start_i latches operands, then one partial
// product per cycle; done_o is high in the last of WIDTH busy cycles with product_o valid.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                busy_q;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [2*WIDTH-1:0]  acc_d;
  logic [WIDTH-1:0]    mplier_q;

  // The final partial product is folded in combinationally so the result
  // is available in the same cycle done_o is raised.
  assign acc_d     = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign done_o    = busy_q && (cnt_q == LAST);
  assign product_o = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, status flags and carry chaining.
// Define ALU_PIPE_MUL_EN to build in the iterative multiplier (MUL/MFHI) and hi register.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             use_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             err_q;

  logic             accept;
  logic             cin_eff;
  logic [WIDTH:0]   ax, bx, cx, sum;
  logic             ovf;
  logic             is_mul;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_d;
  logic             err_d;

  // Handshake: a beat moves on an interface in any cycle where valid and ready
  // are both high at the rising edge; valid never depends on ready. The input
  // side stalls while the multiplier runs or while an unconsumed result sits
  // in the output register.
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

  assign cin_eff = use_cf ? flags_q[FLAG_C] : c_in;
  assign ax      = {1'b0, a};
  assign bx      = {1'b0, b};
  assign cx      = {{WIDTH{1'b0}}, cin_eff};

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0]   hi_q;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && is_mul),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hi_q <= '0;
    else if (state_q == BUSY && mul_done) hi_q <= product[2*WIDTH-1:WIDTH];
  end
`endif

  // Datapath: the top bit of the WIDTH+1 result is carry/borrow for the
  // arithmetic group and always zero for logic and pass ops.
  always_comb begin
    sum = '0;
    ovf = 1'b0;
    case (op)
      ADD:   begin sum = ax + bx + cx; ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]); end
      SUB:   begin sum = ax - bx - cx; ovf = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]); end
      INCA:  begin sum = ax + ONE; ovf = !a[MSB] && sum[MSB]; end
      INCB:  begin sum = bx + ONE; ovf = !b[MSB] && sum[MSB]; end
      DECA:  begin sum = ax - ONE; ovf = a[MSB] && !sum[MSB]; end
      DECB:  begin sum = bx - ONE; ovf = b[MSB] && !sum[MSB]; end
      PASSA: sum = ax;
      PASSB: sum = bx;
      AND:   sum = {1'b0, a & b};
      OR:    sum = {1'b0, a | b};
      XOR:   sum = {1'b0, a ^ b};
      NOR:   sum = {1'b0, ~(a | b)};
      SHLA:  sum = {1'b0, a << SHAMT};
      SHLB:  sum = {1'b0, b << SHAMT};
      SRLA:  sum = {1'b0, a >> SHAMT};
      SRLB:  sum = {1'b0, b >> SHAMT};
      default: ;
    endcase
  end

  always_comb begin
    result_d = '0;
    flags_d  = flags_q;
    err_d    = 1'b0;
    is_mul   = 1'b0;
    if (!op[4]) begin
      result_d = sum[MSB:0];
      flags_d  = {sum[WIDTH], (sum[MSB:0] == '0), sum[MSB], ovf};
    end else begin
`ifdef ALU_PIPE_MUL_EN
      if (op == MUL) begin
        is_mul = 1'b1;
      end else if (op == MFHI) begin
        result_d = hi_q;
        flags_d  = {(hi_q != '0), (hi_q == '0), hi_q[MSB], 1'b0};
      end else begin
        err_d = 1'b1;
      end
`else
      err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= BUSY;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= result_d;
              flags_q     <= flags_d;
              err_q       <= err_d;
            end
          end
        end
        BUSY: begin
`ifdef ALU_PIPE_MUL_EN
          if (mul_done) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            result_q    <= product[MSB:0];
            flags_q     <= {(product[2*WIDTH-1:WIDTH] != '0), (product == '0), product[MSB], 1'b0};
            err_q       <= 1'b0;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8, SHAMT=2); MUL tests run when
// ALU_PIPE_MUL_EN is defined, otherwise MUL/MFHI are expected to be illegal.
module tb_alu_pipe;

  localparam int W  = 8;
  localparam int SH = 2;
  localparam int EW = W + 5;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         use_cf;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [3:0]    m_flags;
  logic [W-1:0]  m_hi;

  alu_pipe #(.WIDTH(W), .SHAMT(SH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .use_cf    (use_cf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: computes the expected beat for the op being accepted
  task automatic model_push();
    int ua, ub, sa, sb, ci, s, sv, p;
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         e, c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    ci = use_cf ? int'(m_flags[3]) : int'(c_in);
    s = 0; sv = 0; r = '0; e = 1'b0; f = m_flags;
    if (op[4:3] == 2'b01) begin
      case (op[2:0])
        3'd0: begin s = ua + ub + ci; sv = sa + sb + ci; end
        3'd1: begin s = ua - ub - ci; sv = sa - sb - ci; end
        3'd2: begin s = ua + 1; sv = sa + 1; end
        3'd3: begin s = ub + 1; sv = sb + 1; end
        3'd4: begin s = ua - 1; sv = sa - 1; end
        3'd5: begin s = ub - 1; sv = sb - 1; end
        3'd6: begin s = ua; sv = sa; end
        default: begin s = ub; sv = sb; end
      endcase
      r = W'(s);
      c = (s < 0) || (s >= (1 << W));
      v = (op[2:0] < 3'd6) && ((sv < -(1 << (W - 1))) || (sv > (1 << (W - 1)) - 1));
      f = {c, (r == '0), r[W-1], v};
    end else if (op[4:3] == 2'b00) begin
      case (op[2:0])
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: r = a ^ b;
        3'd3: r = ~(a | b);
        3'd4: r = W'(ua << SH);
        3'd5: r = W'(ub << SH);
        3'd6: r = W'(ua >> SH);
        default: r = W'(ub >> SH);
      endcase
      f = {1'b0, (r == '0), r[W-1], 1'b0};
    end else begin
`ifdef ALU_PIPE_MUL_EN
      if (op == 5'b1_0000) begin
        p = ua * ub;
        r = W'(p);
        m_hi = W'(p >> W);
        f = {(m_hi != '0), (p == 0), r[W-1], 1'b0};
      end else if (op == 5'b1_0001) begin
        r = m_hi;
        f = {(m_hi != '0), (m_hi == '0), m_hi[W-1], 1'b0};
      end else begin
        e = 1'b1;
      end
`else
      p = 0;
      e = 1'b1;
`endif
    end
    m_flags = f;
    exp_q.push_back({e, f, r});
  endtask

  // scoreboard: compare every consumed result against the expected queue
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e[W-1:0]));
        check("flags",  32'(flags),  32'(e[W+3:W]));
        check("err",    32'(err),    32'(e[W+4]));
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic uc);
    op = o; a = x; b = y; c_in = ci; use_cf = uc; in_valid = 1'b1;
  endtask

  // waits for acceptance of the driven op; returns 1ns after the accept edge
  task automatic commit();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'(1));
    end else begin
      @(posedge clk);
      model_push();
      #1;
    end
  endtask

  task automatic send(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic uc);
    drive(o, x, y, ci, uc);
    commit();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] ro;
    int rsel;
    m_flags   = '0;
    m_hi      = '0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    op = '0; a = '0; b = '0; c_in = 1'b0; use_cf = 1'b0;

    // reset with random inputs toggling
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      op = 5'($urandom_range(0, 31));
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      c_in = 1'($urandom_range(0, 1));
      use_cf = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result",    32'(result),    32'(0));
    check("rst_flags",     32'(flags),     32'(0));
    check("rst_err",       32'(err),       32'(0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // arithmetic, carry chaining back-to-back, overflow
    send(5'b0_1000, 8'hFF, 8'h01, 1'b0, 1'b0);
    send(5'b0_1000, 8'h00, 8'h00, 1'b0, 1'b1);
    send(5'b0_1001, 8'h00, 8'h01, 1'b0, 1'b0);
    send(5'b0_1000, 8'h7F, 8'h01, 1'b0, 1'b0);
    send(5'b0_1001, 8'h80, 8'h01, 1'b0, 1'b0);
    send(5'b0_1000, 8'h10, 8'h20, 1'b1, 1'b0);
    send(5'b0_1010, 8'hFF, 8'h00, 1'b0, 1'b0);
    send(5'b0_1101, 8'h00, 8'h00, 1'b0, 1'b0);
    send(5'b0_1110, 8'h9C, 8'h00, 1'b0, 1'b0);
    // logic group and an illegal ext op
    send(5'b0_0100, 8'h81, 8'h00, 1'b0, 1'b0);
    send(5'b0_0011, 8'h0F, 8'hF0, 1'b0, 1'b0);
    send(5'b0_0111, 8'h00, 8'hF1, 1'b0, 1'b0);
    send(5'b1_0111, 8'h12, 8'h34, 1'b0, 1'b0);
    idle(3);

    // backpressure: result held, in_ready low, second op waits
    out_ready = 1'b0;
    send(5'b0_0010, 8'hAA, 8'h55, 1'b0, 1'b0);
    drive(5'b0_0000, 8'hF0, 8'h3C, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_result",    32'(result),    32'(8'hFF));
      check("bp_flags",     32'(flags),     32'(4'b0010));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    commit();
    idle(3);

`ifdef ALU_PIPE_MUL_EN
    // multiplier latency and hi readback
    send(5'b1_0000, 8'hFF, 8'hFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int j = 0; j <= W; j++) begin
      @(negedge clk);
      check("mul_latency", 32'(out_valid), 32'(j == W));
    end
    @(posedge clk);
    #1;
    send(5'b1_0001, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(3);

    // reset during BUSY aborts the multiply
    send(5'b1_0000, 8'h03, 8'h05, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    m_flags = '0;
    m_hi    = '0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_result",    32'(result),    32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'(0));
    end
    check("abort_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    send(5'b1_0001, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(2);
`else
    send(5'b1_0000, 8'hFF, 8'hFF, 1'b0, 1'b0);
    send(5'b1_0001, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(2);
`endif

    // random single-cycle ops with random output backpressure
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      rsel = $urandom_range(0, 17);
      ro = (rsel < 16) ? 5'(rsel) : 5'b1_0111;
      send(ro, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // drain
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
